// File: rtl/top_uart_rx.sv
// top_uart_rx: memory-mapped 8N1 UART receiver for the local bus.
// Synchronises the serial input, recovers bytes with a mid-bit sampling
// state machine and buffers them in a FIFO drained through four registers.
//
// Ports:
//   i_clk          global clock
//   i_rst          asynchronous active-high reset
//   i_sel          block selected by the local bus decoder
//   i_addr         byte address, only [3:2] decoded
//   i_wdata        write data
//   i_we           byte write enables, any nonzero value is a write
//   o_rdata        read data, zero when not selected
//   i_rxd          serial input, idle high
//   o_int_uart_rx  level interrupt: inten & (valid | overrun | ferr)
//
// Registers (addr[3:2]):
//   0 RXDATA  [7:0] FIFO head (0 when empty), reading does not pop
//   1 STATUS  0 valid, 1 full, 2 overrun (W1C), 3 ferr (W1C), [12:8] count
//   2 CTRL    0 rxen, 1 inten
//   3 POP     any write pops one entry, reads 0
module top_uart_rx #(
    parameter int AWIDTH = 14,
    parameter int DIV    = 868,
    parameter int DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_we,
    output logic [31:0]       o_rdata,
    input  logic              i_rxd,
    output logic              o_int_uart_rx
);

    localparam int CNTW = $clog2(DIV);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [CNTW-1:0] C_HALF = CNTW'(DIV / 2 - 1);
    localparam logic [CNTW-1:0] C_FULL = CNTW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Receiver state
    logic            r_sync1;
    logic            r_sync2;
    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic [2:0]      r_bitidx;
    logic [7:0]      r_shift;
    logic            r_armed;
    logic            r_push;
    logic            r_ferr_evt;

    // FIFO
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    // Control / status
    logic            r_overrun;
    logic            r_ferr;
    logic [1:0]      r_ctrl;
    logic            r_int;

    // Bus decode
    logic            w_wr;
    logic [1:0]      w_reg;
    logic            w_pop_req;
    logic            w_stat_wr;
    logic            w_ctrl_wr;
    logic            w_empty;
    logic            w_full;
    logic            w_do_pop;
    logic            w_do_push;
    logic            w_ovr_set;
    logic [7:0]      w_head;
    logic [4:0]      w_cnt5;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_wr      = i_sel & (|i_we);
    assign w_reg     = i_addr[3:2];
    assign w_pop_req = w_wr & (w_reg == 2'd3);
    assign w_stat_wr = w_wr & i_we[0] & (w_reg == 2'd1);
    assign w_ctrl_wr = w_wr & i_we[0] & (w_reg == 2'd2);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = w_pop_req & ~w_empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign w_do_push = r_push & (~w_full | w_do_pop);
    assign w_ovr_set = r_push & w_full & ~w_do_pop;

    assign w_head    = w_empty ? '0 : r_mem[r_rptr];
    assign w_cnt5    = 5'(r_count);
    assign w_status  = {19'b0, w_cnt5, 4'b0, r_ferr, r_overrun, w_full, ~w_empty};

    assign w_unused  = ^{i_addr[AWIDTH-1:4], i_addr[1:0], i_wdata[31:4]};

    // Receive state machine with input synchroniser.
    // r_armed blocks start detection until the line has been seen high,
    // so a low stop bit (framing error) is not mistaken for a new start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitidx   <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b1;
            r_push     <= 1'b0;
            r_ferr_evt <= 1'b0;
        end else begin
            r_sync1    <= i_rxd;
            r_sync2    <= r_sync1;
            r_push     <= 1'b0;
            r_ferr_evt <= 1'b0;
            if (!r_ctrl[0]) begin
                r_state <= S_IDLE;
                r_armed <= r_sync2;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (r_sync2) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state <= S_START;
                            r_cnt   <= C_HALF;
                        end
                    end
                    S_START: begin
                        if (r_cnt == '0) begin
                            if (!r_sync2) begin
                                r_state  <= S_DATA;
                                r_bitidx <= '0;
                                r_cnt    <= C_FULL;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNTW'(1);
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == '0) begin
                            r_shift <= {r_sync2, r_shift[7:1]};
                            r_cnt   <= C_FULL;
                            if (r_bitidx == 3'd7) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bitidx <= r_bitidx + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNTW'(1);
                        end
                    end
                    S_STOP: begin
                        if (r_cnt == '0) begin
                            r_push     <= r_sync2;
                            r_ferr_evt <= ~r_sync2;
                            r_armed    <= r_sync2;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CNTW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO storage has no reset; empty entries are masked on read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky flags: a set in the same cycle as W1C wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
            r_ctrl    <= 2'b01;
            r_int     <= 1'b0;
        end else begin
            r_overrun <= (r_overrun & ~(w_stat_wr & i_wdata[2])) | w_ovr_set;
            r_ferr    <= (r_ferr & ~(w_stat_wr & i_wdata[3])) | r_ferr_evt;
            if (w_ctrl_wr) begin
                r_ctrl <= i_wdata[1:0];
            end
            r_int <= r_ctrl[1] & (~w_empty | r_overrun | r_ferr);
        end
    end

    assign o_int_uart_rx = r_int;

    always_comb begin
        o_rdata = '0;
        if (i_sel) begin
            unique case (w_reg)
                2'd0:    o_rdata = {24'b0, w_head};
                2'd1:    o_rdata = w_status;
                2'd2:    o_rdata = {30'b0, r_ctrl};
                default: o_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_top_uart_rx.sv
// Directed bench for top_uart_rx with DIV=16, DEPTH=4.
// Inputs change on the falling clock edge; outputs are read there too.
module tb_top_uart_rx;

    localparam int AW    = 14;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_CTRL = 4'h8;
    localparam logic [3:0] A_POP  = 4'hC;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    we;
    logic [31:0]   rdata;
    logic          rxd;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;

    top_uart_rx #(.AWIDTH(AW), .DIV(DIV), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sel         (sel),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .i_we          (we),
        .o_rdata       (rdata),
        .i_rxd         (rxd),
        .o_int_uart_rx (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        sel  = 1'b1;
        addr = AW'(a);
        we   = 4'h0;
        #1 d = rdata;
        sel  = 1'b0;
        addr = '0;
        @(negedge clk);
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] w);
        sel   = 1'b1;
        addr  = AW'(a);
        wdata = d;
        we    = w;
        @(negedge clk);
        sel   = 1'b0;
        addr  = '0;
        wdata = '0;
        we    = 4'h0;
    endtask

    // One 8N1 frame, LSB first, followed by 8 idle cycles (168 cycles total).
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        sel   = 1'b0;
        addr  = '0;
        wdata = '0;
        we    = 4'h0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_irq", {31'b0, irq}, 32'h0);
        chk_reg("rst_status", A_STAT, 32'h0);
        chk_reg("rst_ctrl", A_CTRL, 32'h1);
        chk_reg("rst_rxdata", A_DATA, 32'h0);
        chk_reg("rst_popread", A_POP, 32'h0);

        // Single byte
        send_byte(8'hA5, 1'b1);
        chk_reg("a5_status", A_STAT, 32'h101);
        chk_reg("a5_rxdata", A_DATA, 32'hA5);
        chk_reg("a5_reread", A_DATA, 32'hA5);
        sel  = 1'b0;
        addr = AW'(A_DATA);
        #1 check_eq("unsel_rdata", rdata, 32'h0);
        @(negedge clk);
        wr(A_POP, 32'h0, 4'hF);
        chk_reg("a5_popped", A_STAT, 32'h0);
        chk_reg("a5_empty_data", A_DATA, 32'h0);

        // Overflow: five bytes into four entries
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        // valid, full, overrun, count 4
        chk_reg("ovr_status", A_STAT, 32'h407);
        for (int i = 1; i <= 4; i++) begin
            chk_reg($sformatf("ovr_data%0d", i), A_DATA, 32'(i));
            wr(A_POP, 32'h0, 4'h1);
        end
        chk_reg("ovr_drained", A_STAT, 32'h004);
        wr(A_POP, 32'h0, 4'h1);
        chk_reg("pop_empty", A_STAT, 32'h004);
        wr(A_STAT, 32'h4, 4'h2);
        chk_reg("w1c_no_we0", A_STAT, 32'h004);
        wr(A_STAT, 32'h4, 4'h1);
        chk_reg("ovr_cleared", A_STAT, 32'h0);

        // Framing error, then a good frame
        send_byte(8'h3C, 1'b0);
        chk_reg("ferr_status", A_STAT, 32'h008);
        send_byte(8'h3C, 1'b1);
        chk_reg("ferr_next_status", A_STAT, 32'h109);
        chk_reg("ferr_next_data", A_DATA, 32'h3C);
        wr(A_STAT, 32'h8, 4'h1);
        wr(A_POP, 32'h0, 4'h1);
        chk_reg("ferr_cleared", A_STAT, 32'h0);

        // 4-cycle glitch, then a frame starting 13 cycles after it
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        chk_reg("glitch_status", A_STAT, 32'h0);
        send_byte(8'h5A, 1'b1);
        chk_reg("glitch_next_status", A_STAT, 32'h101);
        chk_reg("glitch_next_data", A_DATA, 32'h5A);
        wr(A_POP, 32'h0, 4'h1);

        // Interrupt
        wr(A_CTRL, 32'h3, 4'h1);
        chk_reg("ctrl_rw", A_CTRL, 32'h3);
        check_eq("irq_empty", {31'b0, irq}, 32'h0);
        send_byte(8'h11, 1'b1);
        check_eq("irq_pending", {31'b0, irq}, 32'h1);
        wr(A_POP, 32'h0, 4'h1);
        check_eq("irq_pop_plus1", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check_eq("irq_pop_plus2", {31'b0, irq}, 32'h0);

        // Pop coincident with a stop-bit push (push lands at the 156th edge)
        send_byte(8'h22, 1'b1);
        chk_reg("ovl_before", A_STAT, 32'h101);
        fork
            send_byte(8'h33, 1'b1);
            begin
                repeat (155) @(negedge clk);
                sel  = 1'b1;
                addr = AW'(A_POP);
                we   = 4'hF;
                @(negedge clk);
                sel  = 1'b0;
                addr = '0;
                we   = 4'h0;
            end
        join
        chk_reg("ovl_status", A_STAT, 32'h101);
        chk_reg("ovl_data", A_DATA, 32'h33);
        check_eq("ovl_irq", {31'b0, irq}, 32'h1);

        // Reset during bit 3 with a byte pending and CTRL=0x3
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (72) @(negedge clk);
                rst = 1'b1;
                #1 check_eq("midrst_irq", {31'b0, irq}, 32'h0);
                @(negedge clk);
                chk_reg("midrst_status", A_STAT, 32'h0);
                chk_reg("midrst_ctrl", A_CTRL, 32'h1);
                chk_reg("midrst_data", A_DATA, 32'h0);
            end
        join
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h7E, 1'b1);
        chk_reg("postrst_status", A_STAT, 32'h101);
        chk_reg("postrst_data", A_DATA, 32'h7E);
        check_eq("postrst_irq", {31'b0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
